// File: rtl/gpio_bus_master.sv
// GPIO register bus initiator. CPU-side commands queue in a small FIFO. Each
// command becomes one gpio_en strobe toward the GPIO IP, or an immediate error
// response if the access is illegal. Exactly one response is returned per
// command, and responses come back in command order.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a queued command and for the inter-strobe gap to expire
// S_ISSUE | gpio_en high for this single cycle
// S_WAIT  | read issued; counting down the read latency before sampling bus_rdata
// S_RESP  | response presented; held stable until rsp_ready
module gpio_bus_master #(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          RD_LAT     = 1,
   parameter int          GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [3:0]  cmd_offset,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        gpio_en,
   output logic        write_enable,
   output logic [31:0] gpio_addr,
   output logic [31:0] gpio_wdata,
   input  logic [31:0] bus_rdata
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam int LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   logic          r_rdy;
   logic          r_is_rd;
   logic          r_strobed;
   logic [GW-1:0] r_gap;
   logic [LW-1:0] r_lat;

   logic          r_fifo_we  [FIFO_DEPTH];
   logic [3:0]    r_fifo_off [FIFO_DEPTH];
   logic [31:0]   r_fifo_wd  [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_head_we;
   logic [3:0]    w_head_off;
   logic [31:0]   w_head_wd;
   logic          w_legal;

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push     = cmd_valid && cmd_ready;
   assign w_pop      = (r_state == S_IDLE) && !w_empty && (r_gap == '0);
   assign w_head_we  = r_fifo_we[r_rd_ptr];
   assign w_head_off = r_fifo_off[r_rd_ptr];
   assign w_head_wd  = r_fifo_wd[r_rd_ptr];
   // DATA and DIR accept reads and writes; READ is read-only; all other offsets are rejected.
   assign w_legal    = (w_head_off == 4'h0) || (w_head_off == 4'h4) ||
                       ((w_head_off == 4'h8) && !w_head_we);

   // r_rdy keeps cmd_ready low while in reset; a full FIFO refuses even if it pops this cycle.
   assign cmd_ready  = r_rdy && !w_full;
   assign busy       = !w_empty || (r_state != S_IDLE);

   // FIFO storage is not reset; the pointers and count below define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_we[r_wr_ptr]  <= cmd_we;
         r_fifo_off[r_wr_ptr] <= cmd_offset;
         r_fifo_wd[r_wr_ptr]  <= cmd_wdata;
      end
   end

   // FIFO pointers and occupancy count; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Bus sequencing FSM. Outputs are registered; the gap and latency timers count down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rdy        <= 1'b0;
         r_is_rd      <= 1'b0;
         r_strobed    <= 1'b0;
         r_gap        <= '0;
         r_lat        <= '0;
         gpio_en      <= 1'b0;
         write_enable <= 1'b0;
         gpio_addr    <= '0;
         gpio_wdata   <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (r_gap != '0) r_gap <= r_gap - GW'(1);
               if (w_pop) begin
                  if (w_legal) begin
                     r_state      <= S_ISSUE;
                     gpio_en      <= 1'b1;
                     write_enable <= w_head_we;
                     gpio_addr    <= BASE_ADDR + {28'b0, w_head_off};
                     gpio_wdata   <= w_head_we ? w_head_wd : 32'h0;
                     r_is_rd      <= !w_head_we;
                     r_strobed    <= 1'b1;
                  end else begin
                     // An illegal access produces an error response and never reaches the bus.
                     r_state   <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     r_strobed <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               gpio_en      <= 1'b0;
               write_enable <= 1'b0;
               if (r_is_rd) begin
                  r_state <= S_WAIT;
                  r_lat   <= LW'(RD_LAT - 1);
               end else begin
                  r_state   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
               end
            end
            S_WAIT: begin
               if (r_lat == '0) begin
                  r_state   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= bus_rdata;
               end else begin
                  r_lat <= r_lat - LW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state   <= S_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
                  if (r_strobed) r_gap <= GW'(GAP_CYCLES);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master with default parameters. Outputs are sampled
// on the falling clock edge, and inputs change just after the rising edge or on
// the falling edge.
module tb_gpio_bus_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [3:0]  cmd_offset;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        gpio_en, write_enable;
   logic [31:0] gpio_addr, gpio_wdata, bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   gpio_bus_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .gpio_en(gpio_en), .write_enable(write_enable),
      .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // strobe log and bus-rule monitor
   logic [31:0] log_wd[$];
   logic [31:0] log_addr[$];
   logic        prev_en = 1'b0;
   logic        prev_rv = 1'b0;
   int          en_long = 0;
   int          we_bad  = 0;
   int          idle_cnt = 100;
   int          last_idle = 100;

   always @(negedge clk) begin
      if (gpio_en) begin
         log_wd.push_back(gpio_wdata);
         log_addr.push_back(gpio_addr);
         last_idle = idle_cnt;
         if (prev_en) en_long++;
      end
      if (write_enable && !gpio_en) we_bad++;
      if (prev_rv && !rsp_valid) idle_cnt = 1;
      else idle_cnt++;
      prev_en = gpio_en;
      prev_rv = rsp_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic we, input logic [3:0] off, input logic [31:0] wd);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_offset = off; cmd_wdata = wd;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gpio_en && n < 50);
      chk("strobe_seen", 32'(gpio_en), 1);
   endtask

   task automatic get_rsp(input string tag, input logic err, input logic [31:0] rd);
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 1);
      chk({tag, "_err"}, 32'(rsp_err), 32'(err));
      chk({tag, "_rdata"}, rsp_rdata, rd);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   int lat;
   int base;
   int rv_seen;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_offset = '0;
      cmd_wdata = '0; rsp_ready = 1'b0; bus_rdata = '0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_gpio_en", 32'(gpio_en), 0);
      chk("rst_addr", gpio_addr, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

      // write DIR
      push(1'b1, 4'h4, 32'hAAAA_AAAA);
      wait_strobe(lat);
      chk("wr_latency", 32'(lat), 2);
      chk("wr_we", 32'(write_enable), 1);
      chk("wr_addr", gpio_addr, 32'h2000_0004);
      chk("wr_wdata", gpio_wdata, 32'hAAAA_AAAA);
      chk("wr_busy", 32'(busy), 1);
      @(negedge clk);
      chk("wr_en_drop", 32'(gpio_en), 0);
      chk("wr_we_drop", 32'(write_enable), 0);
      chk("wr_rsp_next", 32'(rsp_valid), 1);
      chk("wr_addr_hold", gpio_addr, 32'h2000_0004);
      get_rsp("wr", 1'b0, 32'h0);
      repeat (6) @(negedge clk);
      chk("wr_idle_busy", 32'(busy), 0);

      // read READ reg
      push(1'b0, 4'h8, 32'h5555_5555);
      wait_strobe(lat);
      chk("rd_latency", 32'(lat), 2);
      chk("rd_we", 32'(write_enable), 0);
      chk("rd_addr", gpio_addr, 32'h2000_0008);
      chk("rd_wdata", gpio_wdata, 32'h0);
      @(posedge clk);
      #1 bus_rdata = 32'hCAFE_BABE;
      @(negedge clk);
      chk("rd_rsp_early", 32'(rsp_valid), 0);
      @(posedge clk);
      #1 bus_rdata = 32'h0;
      @(negedge clk);
      chk("rd_rsp_time", 32'(rsp_valid), 1);
      get_rsp("rd", 1'b0, 32'hCAFE_BABE);
      repeat (6) @(negedge clk);

      // back-to-back writes
      base = log_wd.size();
      push(1'b1, 4'h0, 32'h1111_1111);
      push(1'b1, 4'h0, 32'h2222_2222);
      get_rsp("b2b0", 1'b0, 32'h0);
      get_rsp("b2b1", 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      chk("b2b_count", 32'(log_wd.size() - base), 2);
      chk("b2b_first", log_wd[base], 32'h1111_1111);
      chk("b2b_second", log_wd[base+1], 32'h2222_2222);
      chk("b2b_addr", log_addr[base+1], 32'h2000_0000);
      chk("b2b_gap", 32'(last_idle >= 2), 1);
      repeat (6) @(negedge clk);

      // full / backpressure: one in flight plus four queued
      base = log_wd.size();
      for (int k = 1; k <= 5; k++) push(1'b1, 4'h0, 32'(k));
      @(negedge clk);
      chk("full_ready", 32'(cmd_ready), 0);
      chk("full_busy", 32'(busy), 1);
      repeat (3) @(negedge clk);
      chk("full_ready_hold", 32'(cmd_ready), 0);
      for (int k = 1; k <= 5; k++) get_rsp("drain", 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      chk("drain_count", 32'(log_wd.size() - base), 5);
      for (int k = 1; k <= 5; k++) chk("drain_order", log_wd[base+k-1], 32'(k));
      chk("drain_ready", 32'(cmd_ready), 1);
      repeat (6) @(negedge clk);

      // illegal accesses
      base = log_wd.size();
      bus_rdata = 32'hDEAD_BEEF;
      push(1'b1, 4'h8, 32'h1234_5678);
      push(1'b0, 4'hC, 32'h0);
      get_rsp("ill0", 1'b1, 32'h0);
      get_rsp("ill1", 1'b1, 32'h0);
      repeat (3) @(negedge clk);
      chk("ill_no_strobe", 32'(log_wd.size() - base), 0);
      bus_rdata = 32'h0;
      repeat (4) @(negedge clk);

      // reset during read wait
      push(1'b0, 4'h0, 32'h0);
      wait_strobe(lat);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 32'(gpio_en), 0);
      chk("mid_rst_rsp", 32'(rsp_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      rv_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid || gpio_en) rv_seen++;
      end
      chk("mid_rst_no_rsp", 32'(rv_seen), 0);
      chk("mid_rst_ready", 32'(cmd_ready), 1);
      chk("mid_rst_idle", 32'(busy), 0);

      chk("en_one_cycle", 32'(en_long), 0);
      chk("we_without_en", 32'(we_bad), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
